// File: rtl/aes128_inv_cipher_iter_pkg.sv
// AES-128 inverse cipher shared types and GF(2^8) helpers.
// Holds the FSM encoding, round constants and the byte/state transforms.
package aes128_inv_cipher_iter_pkg;

   localparam int AES_NR = 10;
   localparam logic [3:0] RK_LAST = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] acc;
      p   = a;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [7:0] gmul_09(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ x;
   endfunction

   function automatic logic [7:0] gmul_0b(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
   endfunction

   function automatic logic [7:0] gmul_0d(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
   endfunction

   function automatic logic [7:0] gmul_0e(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
   endfunction

   // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box needs
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   // Undo the forward S-box affine map before inversion
   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   // Byte n sits at [127-8n -: 8], row n%4, column n/4
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {
            gmul_0e(a0) ^ gmul_0b(a1) ^ gmul_0d(a2) ^ gmul_09(a3),
            gmul_09(a0) ^ gmul_0e(a1) ^ gmul_0b(a2) ^ gmul_0d(a3),
            gmul_0d(a0) ^ gmul_09(a1) ^ gmul_0e(a2) ^ gmul_0b(a3),
            gmul_0b(a0) ^ gmul_0d(a1) ^ gmul_09(a2) ^ gmul_0e(a3)};
      end
      return o;
   endfunction

endpackage

// File: rtl/aes128_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out ready/valid bundle.
// slave: the decryptor; master: source+sink driving it.
interface aes128_inv_cipher_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ct_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] pt_out;

   modport master (
      output in_valid, ct_in, out_ready,
      input  in_ready, out_valid, pt_out
   );

   modport slave (
      input  in_valid, ct_in, out_ready,
      output in_ready, out_valid, pt_out
   );
endinterface

// File: rtl/aes128_inv_cipher_iter_sbox.sv
// AES inverse S-box, combinational 8-bit lookup.
// Ports: a_i byte in, y_o InvSubBytes(a_i).
module aes128_inv_cipher_iter_sbox
   import aes128_inv_cipher_iter_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   assign y_o = gf_inv(inv_affine(a_i));
endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryptor, one round per clock, 11 cycles/block.
// Ports: clk, rst_n (sync low), bus (ct in / pt out), rk_addr/rk_data key port, busy.
module aes128_inv_cipher_iter
   import aes128_inv_cipher_iter_pkg::*;
#(
   parameter int NR      = AES_NR,
   parameter int KADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   aes128_inv_cipher_iter_if.slave  bus,
   output logic [KADDR_W-1:0]       rk_addr,
   input  logic [127:0]             rk_data,
   output logic                     busy
);
   localparam logic [KADDR_W-1:0] RK_TOP    = KADDR_W'(NR);
   localparam logic [KADDR_W-1:0] RND_FIRST = KADDR_W'(NR - 1);
   localparam logic [KADDR_W-1:0] RND_ONE   = KADDR_W'(1);

   state_t               state_q;
   logic [KADDR_W-1:0]   rnd_q;
   logic [127:0]         st_q;
   logic                 out_valid_q;

   logic [127:0]         isr;
   logic [127:0]         sb;
   logic [127:0]         ark;
   logic [127:0]         st_round_d;
   logic [127:0]         st_load_d;

   assign isr = inv_shift_rows(st_q);

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes128_inv_cipher_iter_sbox u_sbox (
         .a_i (isr[8*i +: 8]),
         .y_o (sb[8*i +: 8])
      );
   end

   // FINAL uses ark directly, skipping InvMixColumns
   assign ark        = sb ^ rk_data;
   assign st_round_d = inv_mix_columns(ark);
   assign st_load_d  = bus.ct_in ^ rk_data;

   assign bus.in_ready  = (state_q == S_IDLE) ||
                          ((state_q == S_DONE) && bus.out_ready);
   assign bus.out_valid = out_valid_q;
   assign bus.pt_out    = st_q;
   assign busy          = (state_q == S_ROUND) || (state_q == S_FINAL);

   always_comb begin
      rk_addr = RK_TOP;
      case (state_q)
         S_ROUND: rk_addr = rnd_q;
         S_FINAL: rk_addr = '0;
         default: rk_addr = RK_TOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rnd_q       <= '0;
         st_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  st_q    <= st_load_d;
                  rnd_q   <= RND_FIRST;
                  state_q <= S_ROUND;
               end
            end
            S_ROUND: begin
               st_q  <= st_round_d;
               rnd_q <= rnd_q - RND_ONE;
               if (rnd_q == RND_ONE) state_q <= S_FINAL;
            end
            S_FINAL: begin
               st_q        <= ark;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               // Output handshake may coincide with the next accept
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (bus.in_valid) begin
                     st_q    <= st_load_d;
                     rnd_q   <= RND_FIRST;
                     state_q <= S_ROUND;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
